// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry frame receiver.
// Covers the frame-parser state encoding, frame geometry and default sync bytes.
package telem_pkg;

  typedef enum logic [2:0] {
    HUNT1  = 3'd0,
    HUNT2  = 3'd1,
    BATT_H = 3'd2,
    BATT_L = 3'd3,
    CURR_H = 3'd4,
    CURR_L = 3'd5,
    TRQ_H  = 3'd6,
    TRQ_L  = 3'd7
  } state_e;

  localparam int         FRAME_LEN = 8;
  localparam logic [7:0] SYNC1_DEF = 8'hAA;
  localparam logic [7:0] SYNC2_DEF = 8'h55;

  // High bytes carry a 4-bit payload; a nonzero upper nibble marks a corrupt frame.
  function automatic logic nib_ok_f(input logic [7:0] b);
    return (b[7:4] == 4'h0);
  endfunction

endpackage

// File: rtl/telem_frame_rx.sv
// Telemetry frame parser behind UART_rcv: reassembles AA 55 framed 12-bit
// battery/current/torque words and publishes them atomically with status pulses.
module telem_frame_rx
  import telem_pkg::*;
#(
  parameter logic [7:0]       SYNC1   = SYNC1_DEF,
  parameter logic [7:0]       SYNC2   = SYNC2_DEF,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'd10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        frm_vld,
  output logic        sync_err,
  output logic        fmt_err,
  output logic        tmo_err,
  output logic [15:0] frm_cnt
);

  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_ONE;

  state_e            state_r, state_nxt_s;
  logic              rdy_r;
  logic              accept_s;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [11:0]       batt_sh_r, curr_sh_r;
  logic [3:0]        trq_sh_r;
  logic              sync_err_s, fmt_err_s, tmo_err_s, frm_done_s;
  logic              clr_rdy_r, frm_vld_r, sync_err_r, fmt_err_r, tmo_err_r;
  logic [11:0]       batt_r, curr_r, torque_r;
  logic [15:0]       frm_cnt_r;

  assign accept_s = rdy & ~rdy_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HUNT1;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and one-cycle event strobes; an accept always beats expiry
  always_comb begin
    state_nxt_s = state_r;
    sync_err_s  = 1'b0;
    fmt_err_s   = 1'b0;
    tmo_err_s   = 1'b0;
    frm_done_s  = 1'b0;
    if (accept_s) begin
      case (state_r)
        HUNT1: begin
          if (rx_data == SYNC1) state_nxt_s = HUNT2;
          else                  state_nxt_s = HUNT1;
        end
        HUNT2: begin
          if (rx_data == SYNC1) begin
            state_nxt_s = HUNT2;
          end else if (rx_data == SYNC2) begin
            state_nxt_s = BATT_H;
          end else begin
            state_nxt_s = HUNT1;
            sync_err_s  = 1'b1;
          end
        end
        BATT_H, CURR_H, TRQ_H: begin
          if (nib_ok_f(rx_data)) begin
            state_nxt_s = state_e'(state_r + 3'd1);
          end else begin
            fmt_err_s   = 1'b1;
            state_nxt_s = (rx_data == SYNC1) ? HUNT2 : HUNT1;
          end
        end
        BATT_L, CURR_L: state_nxt_s = state_e'(state_r + 3'd1);
        TRQ_L: begin
          frm_done_s  = 1'b1;
          state_nxt_s = HUNT1;
        end
        default: state_nxt_s = HUNT1;
      endcase
    end else if ((state_r != HUNT1) && (tmo_cnt_r == TMO_LAST)) begin
      tmo_err_s   = 1'b1;
      state_nxt_s = HUNT1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Inter-byte timeout counter, idle only while hunting for the first sync byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == HUNT1) || accept_s || tmo_err_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
    end
  end

  // Rdy edge detect, shadow capture of partial frame fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r     <= 1'b0;
      batt_sh_r <= 12'h000;
      curr_sh_r <= 12'h000;
      trq_sh_r  <= 4'h0;
    end else begin
      rdy_r <= rdy;
      if (accept_s) begin
        case (state_r)
          BATT_H:  batt_sh_r[11:8] <= rx_data[3:0];
          BATT_L:  batt_sh_r[7:0]  <= rx_data;
          CURR_H:  curr_sh_r[11:8] <= rx_data[3:0];
          CURR_L:  curr_sh_r[7:0]  <= rx_data;
          TRQ_H:   trq_sh_r        <= rx_data[3:0];
          default: trq_sh_r        <= trq_sh_r;
        endcase
      end
    end
  end

  // Registered outputs: the three words load together only on a completed frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_rdy_r  <= 1'b0;
      frm_vld_r  <= 1'b0;
      sync_err_r <= 1'b0;
      fmt_err_r  <= 1'b0;
      tmo_err_r  <= 1'b0;
      batt_r     <= 12'h000;
      curr_r     <= 12'h000;
      torque_r   <= 12'h000;
      frm_cnt_r  <= 16'h0000;
    end else begin
      clr_rdy_r  <= accept_s;
      frm_vld_r  <= frm_done_s;
      sync_err_r <= sync_err_s;
      fmt_err_r  <= fmt_err_s;
      tmo_err_r  <= tmo_err_s;
      if (frm_done_s) begin
        batt_r    <= batt_sh_r;
        curr_r    <= curr_sh_r;
        torque_r  <= {trq_sh_r, rx_data};
        frm_cnt_r <= frm_cnt_r + 16'd1;
      end
    end
  end

  assign clr_rdy  = clr_rdy_r;
  assign frm_vld  = frm_vld_r;
  assign sync_err = sync_err_r;
  assign fmt_err  = fmt_err_r;
  assign tmo_err  = tmo_err_r;
  assign batt     = batt_r;
  assign curr     = curr_r;
  assign torque   = torque_r;
  assign frm_cnt  = frm_cnt_r;

endmodule

// File: doc/telem_frame_rx.md
Name: telem_frame_rx

Overview:
- Telemetry frame parser downstream of UART_rcv; consumes the eBike TX byte stream.
- Frame is 8 bytes: AA 55, {4'h0,BATT[11:8]}, BATT[7:0], {4'h0,CURR[11:8]}, CURR[7:0], {4'h0,TORQUE[11:8]}, TORQUE[7:0].
- Reassembles and checks frames, then presents BATT/CURR/TORQUE as one atomic word set with a valid pulse and error flags.
- Used in the bench as the telemetry scoreboard front end and reusable on a host-side FPGA.

Parameters:
- SYNC1, 8'hAA, first sync byte
- SYNC2, 8'h55, second sync byte
- TMO_W, 16, width of inter-byte timeout counter
- TMO_CYC, 16'd10000, idle clocks mid-frame before abort (must be > one UART byte time)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  byte-ready from UART_rcv
- rx_data  in  8  received byte from UART_rcv
- clr_rdy  out  1  clear-ready pulse to UART_rcv
- batt  out  12  last good battery value
- curr  out  12  last good current value
- torque  out  12  last good torque value
- frm_vld  out  1  one-cycle pulse when batt/curr/torque update
- sync_err  out  1  one-cycle pulse: SYNC2 mismatch
- fmt_err  out  1  one-cycle pulse: high byte has nonzero upper nibble
- tmo_err  out  1  one-cycle pulse: inter-byte timeout
- frm_cnt  out  16  good-frame count, wraps FFFF->0000

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state HUNT1, timeout counter 0, rdy edge register 0.
- Byte acceptance:
  - A byte is accepted on a rising edge of rdy (rdy & ~rdy_q), registered.
  - rdy held high for multiple cycles yields exactly one accept.
  - clr_rdy is registered high for exactly the cycle after each accept.
- States and transitions on accept:
  - HUNT1: byte==SYNC1 -> HUNT2; any other byte dropped silently, no error.
  - HUNT2: byte==SYNC1 -> stay HUNT2 (handles AA AA 55); byte==SYNC2 -> BATT_H; otherwise -> HUNT1 with sync_err.
  - BATT_H, CURR_H, TRQ_H: upper nibble 0 -> store byte[3:0] in a shadow register and advance. Nonzero upper nibble -> fmt_err; go to HUNT2 if byte==SYNC1, else HUNT1; shadow data discarded.
  - BATT_L, CURR_L: store byte in the shadow register and advance.
  - TRQ_L: on the next clock, load batt/curr/torque from the shadows together with this byte, pulse frm_vld, increment frm_cnt, return to HUNT1.
- Latency: the final byte accept is at cycle N; outputs change and frm_vld is high at cycle N+1.
- Output hold: batt/curr/torque hold their values between good frames and never partially update.
- Timeout:
  - In any state except HUNT1, the counter increments each cycle with no accept and clears on every accept.
  - When the counter equals TMO_CYC-1: pulse tmo_err, clear the counter, go to HUNT1.
  - An accept in the same cycle as expiry wins; no timeout fires.
- Error flags are mutually exclusive per cycle and are never asserted in the same cycle as frm_vld.
- Reset mid-frame returns to the reset state immediately; any partial frame is lost.

Decomposition:
- Package telem_pkg: state enum (HUNT1, HUNT2, BATT_H, BATT_L, CURR_H, CURR_L, TRQ_H, TRQ_L), FRAME_LEN=8, default SYNC1/SYNC2 constants.
- No sub-module: edge detect, FSM, shadows and timeout counter are kept flat in one module.

Test Plan:
- Bytes AA 55 0F FF 01 23 05 00 -> batt=FFF, curr=123, torque=500; one frm_vld pulse one cycle after the last accept; frm_cnt=1; 8 clr_rdy pulses.
- Bytes 12 AA 13, then AA AA 55 0A BC 00 10 07 FF -> one sync_err (on 13); then batt=ABC, curr=010, torque=7FF, frm_cnt=1.
- Good frame, then AA 55 1F 00 ... -> fmt_err on 1F; no frm_vld; outputs keep the previous values; the next good frame is accepted.
- AA 55 01 02, then idle TMO_CYC cycles -> tmo_err exactly once, state HUNT1; the following full frame is accepted.
- rdy held high 5 cycles with one byte -> single accept, single clr_rdy. Reset asserted after 5 bytes of a frame -> all outputs 0; a complete frame after release decodes correctly.
- Preload frm_cnt=FFFF via force, send a good frame -> frm_cnt=0000 and frm_vld pulses.
